// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and funct3 encodings for the memory-access stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane/mask formatting, load shift/extension, legality checks
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic [31:0] ld_data,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted;

  always_comb begin
    illegal    = (is_load & is_store) || (funct3 inside {3'b011, 3'b110, 3'b111});
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = |addr_lo;
      default:     misaligned = 1'b0;
    endcase

    // Size comes from funct3[1:0]; the unsigned bit is meaningless for stores.
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{st_data[7:0]}};
        st_wmask = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_wdata = {2{st_data[15:0]}};
        st_wmask = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        st_wdata = st_data;
        st_wmask = 4'b1111;
      end
    endcase

    shifted = ld_word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'h0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'h0, shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - load/store stage: req/gnt/rvalid bus FSM with timeout and stall
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       alo_q, alo_d;

  logic        op;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_wmask;
  logic        illegal, misaligned;

  // Live execute fields are only meaningful in IDLE; later states use the latched copy.
  assign al_funct3  = (state_q == IDLE) ? ex_funct3    : f3_q;
  assign al_addr_lo = (state_q == IDLE) ? ex_addr[1:0] : alo_q;

  mem_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_load    (ex_load),
    .is_store   (ex_store),
    .st_data    (ex_wdata),
    .ld_word    (dmem_rdata),
    .st_wdata   (st_wdata),
    .st_wmask   (st_wmask),
    .ld_data    (ld_data),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  assign op = ex_valid & (ex_load | ex_store);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    f3_d    = f3_q;
    alo_d   = alo_q;

    case (state_q)
      IDLE: begin
        if (op) begin
          if (illegal || misaligned) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            err_d   = 1'b0;
            we_d    = ex_store;
            addr_d  = {ex_addr[31:2], 2'b00};
            wdata_d = st_wdata;
            wmask_d = ex_store ? st_wmask : 4'b0000;
            f3_d    = ex_funct3;
            alo_d   = ex_addr[1:0];
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? DONE : RESP;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (dmem_rvalid) begin
          state_d = DONE;
          rdata_d = ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      f3_q    <= 3'h0;
      alo_q   <= 2'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
    end
  end

  assign stall      = ((state_q == IDLE) & op) | (state_q == REQ) | (state_q == RESP);
  assign dmem_req   = (state_q == REQ);
  assign lsu_done   = (state_q == DONE);
  assign lsu_err    = (state_q == DONE) & err_q;
  assign lsu_rdata  = rdata_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b0;
  logic [31:0] ex_addr = 32'h0, ex_wdata = 32'h0;
  logic        stall, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .stall(stall), .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one op and plays the memory side; gnt after gnt_dly waiting REQ cycles,
  // rvalid rv_dly cycles after gnt (rv_dly < 0: never).
  task automatic run_op(input string tag, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wmask,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_done_cyc, input int exp_req);
    int   req_cnt = 0;
    int   grant_cyc = -1;
    int   stalls = 0;
    bit   done = 0;
    exp_t e;
    sb.push_back('{exp_rdata, exp_err});
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      if (cyc == 0) begin
        ex_valid = 1'b1; ex_load = ld; ex_store = st;
        ex_funct3 = f3; ex_addr = addr; ex_wdata = wd;
      end
      #1;
      if (lsu_done) begin
        chk({tag, " done_cyc"}, cyc, exp_done_cyc);
        chk({tag, " stall_cycles"}, stalls, exp_done_cyc);
        chk({tag, " stall_in_done"}, {31'h0, stall}, 32'h0);
        chk({tag, " req_cycles"}, req_cnt, exp_req);
        if (sb.size() == 0) begin
          chk({tag, " sb_nonempty"}, 32'h0, 32'h1);
        end else begin
          e = sb.pop_front();
          chk({tag, " lsu_err"}, {31'h0, lsu_err}, {31'h0, e.err});
          chk({tag, " lsu_rdata"}, lsu_rdata, e.rdata);
        end
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        done = 1;
        break;
      end
      stalls += int'(stall);
      if (dmem_req) begin
        if (req_cnt == 0) begin
          chk({tag, " dmem_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
          chk({tag, " dmem_we"}, {31'h0, dmem_we}, {31'h0, st});
          if (st) begin
            chk({tag, " dmem_wdata"}, dmem_wdata, exp_wdata);
            chk({tag, " dmem_wmask"}, {28'h0, dmem_wmask}, {28'h0, exp_wmask});
          end
        end
        if (req_cnt == gnt_dly) begin
          dmem_gnt  = 1'b1;
          grant_cyc = cyc;
        end
        req_cnt++;
      end
      if (grant_cyc >= 0 && rv_dly >= 0 && cyc == grant_cyc + rv_dly) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rd;
      end
    end
    if (!done) begin
      chk({tag, " completed_within_bound"}, 32'h0, 32'h1);
      void'(sb.pop_back());
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    end
  endtask

  initial begin
    #1;
    chk("reset stall", {31'h0, stall}, 32'h0);
    chk("reset lsu_done", {31'h0, lsu_done}, 32'h0);
    chk("reset dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("reset lsu_rdata", lsu_rdata, 32'h0);
    chk("reset dmem_wmask", {28'h0, dmem_wmask}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    //      tag      ld st  f3      addr          wdata         g  rv rdata         exp_wdata     mask  exp_rdata     err done req
    run_op("SW",      0, 1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, -1, 32'h0,        32'hDEAD_BEEF, 4'hF, 32'h0,        0, 2,  1);
    run_op("SB",      0, 1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, -1, 32'h0,        32'hA5A5_A5A5, 4'h8, 32'h0,        0, 2,  1);
    run_op("SH_late", 0, 1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 2, -1, 32'h0,        32'hBEEF_BEEF, 4'hC, 32'h0,        0, 4,  3);
    run_op("LB",      1, 0, 3'b000, 32'h0000_0202, 32'h0,         0, 1,  32'h0080_0000, 32'h0,        4'h0, 32'hFFFF_FF80, 0, 3,  1);
    run_op("LBU",     1, 0, 3'b100, 32'h0000_0202, 32'h0,         0, 1,  32'h0080_0000, 32'h0,        4'h0, 32'h0000_0080, 0, 3,  1);
    run_op("LHU",     1, 0, 3'b101, 32'h0000_0202, 32'h0,         0, 1,  32'h0080_0000, 32'h0,        4'h0, 32'h0000_0080, 0, 3,  1);
    run_op("LH_slow", 1, 0, 3'b001, 32'h0000_0200, 32'h0,         1, 2,  32'h1234_8001, 32'h0,        4'h0, 32'hFFFF_8001, 0, 5,  2);
    run_op("LW",      1, 0, 3'b010, 32'h0000_0300, 32'h0,         0, 1,  32'hCAFE_F00D, 32'h0,        4'h0, 32'hCAFE_F00D, 0, 3,  1);
    run_op("SB_hold", 0, 1, 3'b000, 32'h0000_0301, 32'h0000_0077, 0, -1, 32'h0,        32'h7777_7777, 4'h2, 32'hCAFE_F00D, 0, 2,  1);
    run_op("LW_mis",  1, 0, 3'b010, 32'h0000_0101, 32'h0,         0, 1,  32'h0,        32'h0,        4'h0, 32'h0,        1, 1,  0);
    run_op("LW_ok",   1, 0, 3'b010, 32'h0000_0400, 32'h0,         0, 1,  32'h1122_3344, 32'h0,        4'h0, 32'h1122_3344, 0, 3,  1);
    run_op("L_ill",   1, 0, 3'b011, 32'h0000_0104, 32'h0,         0, 1,  32'h0,        32'h0,        4'h0, 32'h0,        1, 1,  0);
    run_op("LH_mis",  1, 0, 3'b001, 32'h0000_0401, 32'h0,         0, 1,  32'h0,        32'h0,        4'h0, 32'h0,        1, 1,  0);
    run_op("LDST",    1, 1, 3'b010, 32'h0000_0400, 32'h0,         0, 1,  32'h0,        32'h0,        4'h0, 32'h0,        1, 1,  0);
    run_op("LW_ok2",  1, 0, 3'b010, 32'h0000_0404, 32'h0,         0, 1,  32'h5566_7788, 32'h0,        4'h0, 32'h5566_7788, 0, 3,  1);
    run_op("L_tmo",   1, 0, 3'b010, 32'h0000_0500, 32'h0,         3, -1, 32'h0,        32'h0,        4'h0, 32'h0,        1, 1 + 4 + TIMEOUT, 4);
    run_op("S_tmo",   0, 1, 3'b010, 32'h0000_0600, 32'h0BAD_F00D, 1000, -1, 32'h0,     32'h0BAD_F00D, 4'hF, 32'h0,        1, 1 + TIMEOUT, TIMEOUT);
    run_op("LW_ok3",  1, 0, 3'b010, 32'h0000_0700, 32'h0,         0, 1,  32'hA1B2_C3D4, 32'h0,        4'h0, 32'hA1B2_C3D4, 0, 3,  1);

    // Reset while waiting in RESP.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_0800;
    for (int i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
    chk("rst_test req", {31'h0, dmem_req}, 32'h1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    chk("rst_test stall_in_resp", {31'h0, stall}, 32'h1);
    rst = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0;
    #1;
    chk("rst_test outputs", {stall, lsu_done, lsu_err, dmem_req, dmem_we, dmem_wmask},
        {23'h0, 9'h0});
    chk("rst_test lsu_rdata", lsu_rdata, 32'h0);
    chk("rst_test dmem_addr", dmem_addr, 32'h0);
    chk("rst_test dmem_wdata", dmem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op("SW_post", 0, 1, 3'b010, 32'h0000_0104, 32'h1357_9BDF, 0, -1, 32'h0, 32'h1357_9BDF, 4'hF, 32'h0, 0, 2, 1);

    // A valid cycle carrying neither load nor store must be ignored.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nop stall/done/req", {29'h0, stall, lsu_done, dmem_req}, 32'h0);
      @(negedge clk);
    end
    ex_valid = 1'b0;

    chk("scoreboard drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
